// File: rtl/p_hardisc.sv
// Shared types and default widths for the hardisc operand stage.
package p_hardisc;

  typedef logic [4:0] rf_add;

  localparam int XLEN_DEF = 32;
  localparam int NFWD_DEF = 2;

endpackage

// File: rtl/op_fwd_sel.sv
// Single-operand source selector: immediate, x0, youngest forward, or RF.
module op_fwd_sel
  import p_hardisc::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NFWD     = NFWD_DEF,
  parameter bit NEED_RDY = 1'b0
) (
  input  logic                 ruse_i,
  input  rf_add                rs_i,
  input  logic [XLEN-1:0]      imm_i,
  input  logic [XLEN-1:0]      rf_i,
  input  logic [NFWD*5-1:0]    fwd_rd_i,
  input  logic [NFWD-1:0]      fwd_we_i,
  input  logic [NFWD-1:0]      fwd_rdy_i,
  input  logic [NFWD*XLEN-1:0] fwd_val_i,
  output logic [XLEN-1:0]      val_o,
  output logic                 rdy_o
);

  always_comb begin
    val_o = rf_i;
    rdy_o = 1'b1;
    if (!ruse_i) begin
      val_o = imm_i;
    end else if (rs_i == '0) begin
      val_o = '0;
    end else begin
      // Walk oldest to youngest so the lowest index wins.
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (fwd_we_i[k] && fwd_rd_i[k*5 +: 5] == rs_i &&
            (fwd_rdy_i[k] || !NEED_RDY)) begin
          val_o = fwd_val_i[k*XLEN +: XLEN];
          rdy_o = fwd_rdy_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/op_stage_mp.sv
// Operand fetch / forwarding stage with hazard bubbles and OPEX register.
module op_stage_mp
  import p_hardisc::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NOPS      = 2,
  parameter int NFWD      = NFWD_DEF,
  parameter int PAYLOAD_W = 21,
  parameter int CNT_W     = 16
) (
  input  logic                   s_clk_i,
  input  logic                   s_reset_i,
  input  logic                   s_stall_i,
  input  logic                   s_flush_i,
  output logic                   s_stall_o,
  input  logic                   s_id_valid_i,
  input  logic [NOPS*5-1:0]      s_id_rs_i,
  input  logic [NOPS-1:0]        s_id_ruse_i,
  input  logic [NOPS*XLEN-1:0]   s_id_imm_i,
  input  logic [NOPS*XLEN-1:0]   s_rf_val_i,
  input  logic [4:0]             s_id_rd_i,
  input  logic [PAYLOAD_W-1:0]   s_id_payload_i,
  input  logic [NFWD*5-1:0]      s_fwd_rd_i,
  input  logic [NFWD-1:0]        s_fwd_we_i,
  input  logic [NFWD-1:0]        s_fwd_rdy_i,
  input  logic [NFWD*XLEN-1:0]   s_fwd_val_i,
  output logic                   s_ex_valid_o,
  output logic [NOPS*XLEN-1:0]   s_ex_op_o,
  output logic [4:0]             s_ex_rd_o,
  output logic [PAYLOAD_W-1:0]   s_ex_payload_o,
  output logic [CNT_W-1:0]       s_bubble_cnt_o
);

  localparam int OW = NOPS * XLEN;

  logic                 valid_q, valid_d;
  logic [OW-1:0]        op_q, op_d;
  rf_add                rd_q, rd_d;
  logic [PAYLOAD_W-1:0] pay_q, pay_d;
  logic [NOPS*5-1:0]    rs_q, rs_d;
  logic [NOPS-1:0]      ruse_q, ruse_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [OW-1:0]        cap_op;
  logic [OW-1:0]        ref_val;
  logic [OW-1:0]        ref_op;
  logic [NOPS-1:0]      cap_rdy;
  logic [NOPS-1:0]      ref_rdy;
  logic                 hazard;
  logic                 clr;

  for (genvar j = 0; j < NOPS; j++) begin : g_op
    op_fwd_sel #(
      .XLEN(XLEN), .NFWD(NFWD), .NEED_RDY(1'b0)
    ) u_cap (
      .ruse_i   (s_id_ruse_i[j]),
      .rs_i     (s_id_rs_i[j*5 +: 5]),
      .imm_i    (s_id_imm_i[j*XLEN +: XLEN]),
      .rf_i     (s_rf_val_i[j*XLEN +: XLEN]),
      .fwd_rd_i (s_fwd_rd_i),
      .fwd_we_i (s_fwd_we_i),
      .fwd_rdy_i(s_fwd_rdy_i),
      .fwd_val_i(s_fwd_val_i),
      .val_o    (cap_op[j*XLEN +: XLEN]),
      .rdy_o    (cap_rdy[j])
    );

    // Held operands only pick up producers whose value is ready.
    op_fwd_sel #(
      .XLEN(XLEN), .NFWD(NFWD), .NEED_RDY(1'b1)
    ) u_ref (
      .ruse_i   (ruse_q[j]),
      .rs_i     (rs_q[j*5 +: 5]),
      .imm_i    (op_q[j*XLEN +: XLEN]),
      .rf_i     (op_q[j*XLEN +: XLEN]),
      .fwd_rd_i (s_fwd_rd_i),
      .fwd_we_i (s_fwd_we_i),
      .fwd_rdy_i(s_fwd_rdy_i),
      .fwd_val_i(s_fwd_val_i),
      .val_o    (ref_val[j*XLEN +: XLEN]),
      .rdy_o    (ref_rdy[j])
    );

    assign ref_op[j*XLEN +: XLEN] = ref_rdy[j] ?
      ref_val[j*XLEN +: XLEN] : op_q[j*XLEN +: XLEN];
  end

  assign hazard    = s_id_valid_i & ~(&cap_rdy);
  assign s_stall_o = hazard & ~s_flush_i;
  assign clr       = s_reset_i | s_flush_i | (~s_stall_i & hazard);

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    rd_d    = rd_q;
    pay_d   = pay_q;
    rs_d    = rs_q;
    ruse_d  = ruse_q;
    if (clr) begin
      valid_d = 1'b0;
      op_d    = '0;
      rd_d    = '0;
      pay_d   = '0;
      rs_d    = '0;
      ruse_d  = '0;
    end else if (s_stall_i) begin
      op_d    = ref_op;
    end else begin
      valid_d = s_id_valid_i;
      op_d    = cap_op;
      rd_d    = s_id_rd_i;
      pay_d   = s_id_payload_i;
      rs_d    = s_id_rs_i;
      ruse_d  = s_id_ruse_i;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s_reset_i) begin
      cnt_d = '0;
    end else if (s_stall_o && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge s_clk_i) begin
    valid_q <= valid_d;
    op_q    <= op_d;
    rd_q    <= rd_d;
    pay_q   <= pay_d;
    rs_q    <= rs_d;
    ruse_q  <= ruse_d;
    cnt_q   <= cnt_d;
  end

  assign s_ex_valid_o   = valid_q;
  assign s_ex_op_o      = op_q;
  assign s_ex_rd_o      = rd_q;
  assign s_ex_payload_o = pay_q;
  assign s_bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_op_stage_mp.sv
// Scoreboard bench for op_stage_mp: directed cases plus random traffic.
`timescale 1ns/1ps
module tb_op_stage_mp;

  localparam int XLEN = 32;
  localparam int NOPS = 2;
  localparam int NFWD = 2;
  localparam int PW   = 21;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, stall_i, flush_i, stall_o, id_valid;
  logic [NOPS*5-1:0]    id_rs;
  logic [NOPS-1:0]      id_ruse;
  logic [NOPS*XLEN-1:0] id_imm, rf_val;
  logic [4:0]           id_rd;
  logic [PW-1:0]        id_pay;
  logic [NFWD*5-1:0]    f_rd;
  logic [NFWD-1:0]      f_we, f_rdy;
  logic [NFWD*XLEN-1:0] f_val;
  logic                 ex_valid;
  logic [NOPS*XLEN-1:0] ex_op;
  logic [4:0]           ex_rd;
  logic [PW-1:0]        ex_pay;
  logic [CW-1:0]        cnt;

  op_stage_mp #(
    .XLEN(XLEN), .NOPS(NOPS), .NFWD(NFWD),
    .PAYLOAD_W(PW), .CNT_W(CW)
  ) dut (
    .s_clk_i        (clk),
    .s_reset_i      (rst),
    .s_stall_i      (stall_i),
    .s_flush_i      (flush_i),
    .s_stall_o      (stall_o),
    .s_id_valid_i   (id_valid),
    .s_id_rs_i      (id_rs),
    .s_id_ruse_i    (id_ruse),
    .s_id_imm_i     (id_imm),
    .s_rf_val_i     (rf_val),
    .s_id_rd_i      (id_rd),
    .s_id_payload_i (id_pay),
    .s_fwd_rd_i     (f_rd),
    .s_fwd_we_i     (f_we),
    .s_fwd_rdy_i    (f_rdy),
    .s_fwd_val_i    (f_val),
    .s_ex_valid_o   (ex_valid),
    .s_ex_op_o      (ex_op),
    .s_ex_rd_o      (ex_rd),
    .s_ex_payload_o (ex_pay),
    .s_bubble_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                 stall;
    logic                 valid;
    logic [NOPS*XLEN-1:0] op;
    logic [4:0]           rd;
    logic [PW-1:0]        pay;
    logic [CW-1:0]        cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  // Reference state: one OPEX slot described as plain fields.
  logic            m_valid;
  logic [XLEN-1:0] m_op[NOPS];
  logic [4:0]      m_rd;
  logic [PW-1:0]   m_pay;
  logic [4:0]      m_rs[NOPS];
  logic            m_ruse[NOPS];
  int              m_cnt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic m_zero();
    m_valid = 1'b0;
    m_rd    = '0;
    m_pay   = '0;
    for (int j = 0; j < NOPS; j++) begin
      m_op[j]   = '0;
      m_rs[j]   = '0;
      m_ruse[j] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [XLEN-1:0] v[NOPS];
    logic [4:0]      rs;
    logic            haz;
    logic            hazard;
    exp_t            e;
    haz = 1'b0;
    for (int j = 0; j < NOPS; j++) begin
      rs   = id_rs[j*5 +: 5];
      v[j] = rf_val[j*XLEN +: XLEN];
      if (!id_ruse[j]) v[j] = id_imm[j*XLEN +: XLEN];
      else if (rs == 0) v[j] = '0;
      else begin
        for (int k = 0; k < NFWD; k++) begin
          if (f_we[k] && f_rd[k*5 +: 5] == rs) begin
            v[j] = f_val[k*XLEN +: XLEN];
            if (!f_rdy[k]) haz = 1'b1;
            break;
          end
        end
      end
    end
    hazard  = id_valid && haz;
    e.stall = hazard && !flush_i;
    if (rst) m_cnt = 0;
    else if (e.stall && m_cnt < CMAX) m_cnt++;
    if (rst || flush_i || (!stall_i && hazard)) begin
      m_zero();
    end else if (stall_i) begin
      for (int j = 0; j < NOPS; j++) begin
        if (m_ruse[j] && m_rs[j] != 0) begin
          for (int k = 0; k < NFWD; k++) begin
            if (f_we[k] && f_rdy[k] && f_rd[k*5 +: 5] == m_rs[j]) begin
              m_op[j] = f_val[k*XLEN +: XLEN];
              break;
            end
          end
        end
      end
    end else begin
      m_valid = id_valid;
      m_rd    = id_rd;
      m_pay   = id_pay;
      for (int j = 0; j < NOPS; j++) begin
        m_op[j]   = v[j];
        m_rs[j]   = id_rs[j*5 +: 5];
        m_ruse[j] = id_ruse[j];
      end
    end
    e.valid = m_valid;
    for (int j = 0; j < NOPS; j++) e.op[j*XLEN +: XLEN] = m_op[j];
    e.rd  = m_rd;
    e.pay = m_pay;
    e.cnt = CW'(m_cnt);
    q.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear();
    rst = 0; stall_i = 0; flush_i = 0; id_valid = 0;
    id_rs = '0; id_ruse = '0; id_imm = '0; rf_val = '0;
    id_rd = '0; id_pay = '0;
    f_rd = '0; f_we = '0; f_rdy = '0; f_val = '0;
  endtask

  // Monitor: stall is sampled at the edge, registers just after it.
  initial begin
    exp_t e;
    logic st;
    forever begin
      @(posedge clk);
      st = stall_o;
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_stall", 64'(st), 64'(e.stall));
        chk("sb_valid", 64'(ex_valid), 64'(e.valid));
        chk("sb_op", 64'(ex_op), 64'(e.op));
        chk("sb_rd", 64'(ex_rd), 64'(e.rd));
        chk("sb_payload", 64'(ex_pay), 64'(e.pay));
        chk("sb_cnt", 64'(cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    m_zero();
    m_cnt = 0;
    clear();
    rst = 1;
    step();
    step();
    chk("reset_valid", 64'(ex_valid), 0);
    chk("reset_cnt", 64'(cnt), 0);
    rst = 0;

    // Youngest forward beats older one.
    id_valid = 1; id_ruse = 2'b01; id_rs[4:0] = 5;
    id_imm[63:32] = 32'h1234; rf_val = {32'h0, 32'hDEAD};
    f_we = 2'b11; f_rdy = 2'b11; f_rd = {5'd5, 5'd5};
    f_val = {32'hBB, 32'hAA};
    step();
    chk("fwd_op0", 64'(ex_op[31:0]), 64'hAA);
    chk("fwd_valid", 64'(ex_valid), 1);
    chk("imm_op1", 64'(ex_op[63:32]), 64'h1234);

    // Unready producer -> bubble, then capture once ready.
    clear();
    id_valid = 1; id_ruse = 2'b01; id_rs[4:0] = 7;
    f_we = 2'b01; f_rd[4:0] = 7; f_rdy = 2'b00;
    #1 chk("haz_stall", 64'(stall_o), 1);
    step();
    chk("bubble_valid", 64'(ex_valid), 0);
    chk("bubble_cnt", 64'(cnt), 1);
    f_rdy = 2'b01; f_val[31:0] = 32'h11;
    #1 chk("ready_nostall", 64'(stall_o), 0);
    step();
    chk("ready_op0", 64'(ex_op[31:0]), 64'h11);
    chk("ready_valid", 64'(ex_valid), 1);

    // Held operand refreshed from older producer.
    clear();
    id_valid = 1; id_ruse = 2'b10; id_rs[9:5] = 3;
    rf_val[63:32] = 32'h99; id_rd = 9; id_pay = 21'h1ABCD;
    step();
    chk("cap_op1", 64'(ex_op[63:32]), 64'h99);
    stall_i = 1; id_ruse = 2'b00; id_rs = '0;
    id_rd = 4; id_pay = 21'h5;
    f_we = 2'b10; f_rd[9:5] = 3; f_rdy = 2'b10; f_val[63:32] = 32'h55;
    step();
    step();
    chk("hold_op1", 64'(ex_op[63:32]), 64'h55);
    chk("hold_rd", 64'(ex_rd), 9);
    chk("hold_pay", 64'(ex_pay), 64'h1ABCD);
    chk("hold_valid", 64'(ex_valid), 1);

    // Flush overrides stall and hazard.
    flush_i = 1; id_valid = 1; id_ruse = 2'b01; id_rs[4:0] = 7;
    f_we = 2'b01; f_rd[4:0] = 7; f_rdy = 2'b00;
    #1 chk("flush_stall", 64'(stall_o), 0);
    step();
    chk("flush_valid", 64'(ex_valid), 0);
    chk("flush_op", 64'(ex_op), 0);

    // x0 never hazards.
    clear();
    id_valid = 1; id_ruse = 2'b01;
    f_we = 2'b01; f_rdy = 2'b00; f_val[31:0] = 32'hFF;
    #1 chk("x0_stall", 64'(stall_o), 0);
    step();
    chk("x0_op0", 64'(ex_op[31:0]), 0);
    chk("x0_valid", 64'(ex_valid), 1);

    // Counter saturation, then reset mid-bubble.
    clear();
    rst = 1;
    step();
    rst = 0; id_valid = 1; id_ruse = 2'b01; id_rs[4:0] = 7;
    f_we = 2'b01; f_rd[4:0] = 7; f_rdy = 2'b00;
    step(); chk("sat_1", 64'(cnt), 1);
    step(); chk("sat_2", 64'(cnt), 2);
    step(); chk("sat_3", 64'(cnt), 3);
    step(); chk("sat_hold", 64'(cnt), 3);
    rst = 1;
    step();
    chk("rst_cnt", 64'(cnt), 0);
    chk("rst_valid", 64'(ex_valid), 0);
    chk("rst_op", 64'(ex_op), 0);
    chk("rst_rd_pay", 64'({ex_rd, ex_pay}), 0);
    clear();
    #1 chk("rst_nostall", 64'(stall_o), 0);

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) < 3);
      flush_i  = ($urandom_range(0, 99) < 8);
      stall_i  = ($urandom_range(0, 99) < 25);
      id_valid = ($urandom_range(0, 99) < 80);
      for (int j = 0; j < NOPS; j++) begin
        id_rs[j*5 +: 5]       = 5'($urandom_range(0, 3));
        id_ruse[j]            = ($urandom_range(0, 99) < 80);
        id_imm[j*XLEN +: XLEN] = $urandom;
        rf_val[j*XLEN +: XLEN] = $urandom;
      end
      for (int k = 0; k < NFWD; k++) begin
        f_rd[k*5 +: 5]        = 5'($urandom_range(0, 3));
        f_we[k]               = 1'($urandom);
        f_rdy[k]              = 1'($urandom);
        f_val[k*XLEN +: XLEN] = $urandom;
      end
      id_rd  = 5'($urandom);
      id_pay = PW'($urandom);
      step();
    end

    clear();
    step();
    #20;
    chk("drain", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
